// File: rtl/zuart_sdram_loader.sv
`default_nettype none
// ============================================================================
// Module   : zuart_sdram_loader
// Purpose  : 8N1 UART receiver that pairs bytes into 16-bit words and writes
//            them into an SDRAM frame buffer through the call/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module zuart_sdram_loader #(
  parameter int          BAUD_DIV    = 1157,
  parameter int          FRAME_WORDS = 512,
  parameter logic [23:0] BASE_ADDR   = 24'd0
) (
  input  logic        clock1,
  input  logic        rst_n,
  input  logic        RXD,
  output logic [23:0] oAddr,
  output logic [15:0] oData,
  output logic [1:0]  oCall,
  input  logic [1:0]  iDone,
  output logic        oFrameDone,
  output logic        oErr,
  output logic        oOvr,
  output logic        oBusy
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CNT_W-1:0] C_HALF_M1  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL_M1  = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_GAP} wr_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  wr_state_t        w_state_q, w_state_d;
  logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             phase_q, phase_d;
  logic [7:0]       hi_q, hi_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      data_q, data_d;
  logic             pend_q, pend_d;
  logic [15:0]      pend_word_q, pend_word_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic             fd_q, fd_d;

  logic             w_byte_valid;
  logic             w_frame_err;
  logic             w_word_done;
  logic [15:0]      w_word;
  logic             w_unused_done0;

  assign w_unused_done0 = iDone[0];

  always_ff @(posedge clock1 or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      w_state_q   <= W_IDLE;
      idx_q       <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      rxd_meta_q  <= RXD;
      rxd_sync_q  <= rxd_meta_q;
      rxd_prev_q  <= rxd_sync_q;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      w_state_q   <= w_state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
      fd_q        <= fd_d;
    end
  end

  // Receiver: all sampling is done on the synchronised line.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
          bit_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == C_HALF_M1) begin
          cnt_d      = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == C_FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {rxd_sync_q, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == C_FULL_M1) begin
          cnt_d        = '0;
          rx_state_d   = RX_IDLE;
          w_byte_valid = rxd_sync_q;
          w_frame_err  = !rxd_sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign w_word_done = w_byte_valid && phase_q;
  assign w_word      = {hi_q, shreg_q};

  // Byte pairing and write sequencing.
  always_comb begin
    phase_d     = phase_q;
    hi_d        = hi_q;
    w_state_d   = w_state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    err_d       = err_q | w_frame_err;
    ovr_d       = ovr_q;
    fd_d        = 1'b0;

    if (w_byte_valid) begin
      phase_d = !phase_q;
      if (!phase_q) begin
        hi_d = shreg_q;
      end
    end

    case (w_state_q)
      W_IDLE: begin
        if (pend_q) begin
          data_d    = pend_word_q;
          pend_d    = 1'b0;
          w_state_d = W_REQ;
        end
      end
      W_REQ: begin
        if (iDone[1]) begin
          w_state_d = W_GAP;
          fd_d      = (idx_q == C_LAST_IDX);
          idx_d     = (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
        end
      end
      W_GAP:   w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase

    // A word finishing as the current write completes is parked, not dropped.
    if (w_word_done) begin
      if (w_state_q == W_IDLE && !pend_q) begin
        data_d    = w_word;
        w_state_d = W_REQ;
      end else if (w_state_q == W_REQ && iDone[1] && !pend_q) begin
        pend_d      = 1'b1;
        pend_word_d = w_word;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign oAddr      = BASE_ADDR + 24'(idx_q);
  assign oData      = data_q;
  assign oCall      = {(w_state_q == W_REQ), 1'b0};
  assign oFrameDone = fd_q;
  assign oErr       = err_q;
  assign oOvr       = ovr_q;
  assign oBusy      = (rx_state_q != RX_IDLE) || (w_state_q != W_IDLE) || pend_q;

endmodule
`default_nettype wire

// File: tb/tb_zuart_sdram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_zuart_sdram_loader
// Purpose  : Scoreboard bench: UART byte driver, SDRAM done model, write monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zuart_sdram_loader;

  localparam int          BD       = 16;
  localparam int          FW       = 16;
  localparam logic [23:0] BASE     = 24'h000100;
  localparam int          DONE_LAT = 10;

  logic        clock1 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        RXD    = 1'b1;
  logic [23:0] oAddr;
  logic [15:0] oData;
  logic [1:0]  oCall;
  logic [1:0]  iDone;
  logic        oFrameDone, oErr, oOvr, oBusy;

  logic done_bit  = 1'b0;
  logic hold_done = 1'b0;
  logic prev_call = 1'b0;
  int   lat       = 0;
  int   fd_cnt    = 0;
  int   tests     = 0;
  int   fails     = 0;

  typedef struct packed {
    logic [23:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];

  assign iDone = {done_bit, 1'b1};

  zuart_sdram_loader #(
    .BAUD_DIV   (BD),
    .FRAME_WORDS(FW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clock1    (clock1),
    .rst_n     (rst_n),
    .RXD       (RXD),
    .oAddr     (oAddr),
    .oData     (oData),
    .oCall     (oCall),
    .iDone     (iDone),
    .oFrameDone(oFrameDone),
    .oErr      (oErr),
    .oOvr      (oOvr),
    .oBusy     (oBusy)
  );

  always #5 clock1 = ~clock1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM model: done pulses DONE_LAT cycles into a request.
  always @(negedge clock1) begin
    if (!rst_n) begin
      done_bit = 1'b0;
      lat      = 0;
    end else if (done_bit) begin
      done_bit = 1'b0;
      lat      = 0;
    end else if (oCall[1] && !hold_done) begin
      lat++;
      if (lat >= DONE_LAT) done_bit = 1'b1;
    end
  end

  // Monitor: each new write request is checked against the scoreboard.
  always @(negedge clock1) begin
    if (!rst_n) begin
      prev_call = 1'b0;
    end else begin
      if (oCall[1] && !prev_call) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", oAddr, oData);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", 32'(oAddr), 32'(e.a));
          check("write_data", 32'(oData), 32'(e.d));
        end
      end
      if (oFrameDone) fd_cnt++;
      prev_call = oCall[1];
    end
  end

  task automatic expect_write(input logic [23:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RXD = 1'b0;
    repeat (BD) @(negedge clock1);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (BD) @(negedge clock1);
    end
    RXD = stop;
    repeat (BD) @(negedge clock1);
    RXD = 1'b1;
    if (!stop) repeat (BD) @(negedge clock1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && !oBusy) break;
      @(negedge clock1);
    end
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(oBusy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock1);
    check("rst_call",  32'(oCall), 32'd0);
    check("rst_addr",  32'(oAddr), 32'(BASE));
    check("rst_data",  32'(oData), 32'd0);
    check("rst_flags", 32'({oFrameDone, oErr, oOvr, oBusy}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clock1);
    check("post_rst_busy", 32'(oBusy), 32'd0);

    // Full frame: byte n = n, word w = {2w, 2w+1}.
    for (int w = 0; w < FW; w++) begin
      expect_write(BASE + 24'(w), {8'(2 * w), 8'(2 * w + 1)});
    end
    for (int n = 0; n < 2 * FW; n++) begin
      send_byte(8'(n), 1'b1);
    end
    drain("frame");
    check("frame_done_count", 32'(fd_cnt), 32'd1);

    // Index wrapped: next word goes back to the base address.
    expect_write(BASE, 16'hABCD);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    drain("single");
    expect_write(BASE + 24'd1, 16'hEF01);
    send_byte(8'hEF, 1'b1);
    send_byte(8'h01, 1'b1);
    drain("second");

    // Glitch shorter than half a bit.
    RXD = 1'b0;
    repeat (5) @(negedge clock1);
    RXD = 1'b1;
    repeat (3 * BD) @(negedge clock1);
    check("glitch_err",  32'(oErr), 32'd0);
    check("glitch_busy", 32'(oBusy), 32'd0);
    check("glitch_call", 32'(oCall), 32'd0);

    // Framing error on a first byte; pairing restarts cleanly.
    send_byte(8'h77, 1'b0);
    check("ferr_flag", 32'(oErr), 32'd1);
    check("ferr_no_write", 32'(oCall), 32'd0);
    expect_write(BASE + 24'd2, 16'h1234);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    drain("after_ferr");
    check("ferr_sticky", 32'(oErr), 32'd1);
    check("ovr_clear", 32'(oOvr), 32'd0);

    // Overrun: done never arrives, second word is dropped.
    hold_done = 1'b1;
    expect_write(BASE + 24'd3, 16'hAABB);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    repeat (BD) @(negedge clock1);
    check("ovr_flag", 32'(oOvr), 32'd1);
    check("ovr_data_held", 32'(oData), 32'hAABB);
    check("ovr_addr_held", 32'(oAddr), 32'(BASE + 24'd3));
    check("ovr_call_held", 32'(oCall), 32'd2);
    check("ovr_queue", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while the write request is outstanding.
    rst_n = 1'b0;
    #1;
    check("midrst_call",  32'(oCall), 32'd0);
    check("midrst_addr",  32'(oAddr), 32'(BASE));
    check("midrst_data",  32'(oData), 32'd0);
    check("midrst_flags", 32'({oFrameDone, oErr, oOvr, oBusy}), 32'd0);
    repeat (3) @(negedge clock1);
    hold_done = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clock1);
    expect_write(BASE, 16'h5566);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    drain("after_reset");
    check("final_frame_done_count", 32'(fd_cnt), 32'd1);
    check("final_flags", 32'({oErr, oOvr}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zuart_sdram_loader.md
# zuart_sdram_loader

UART receive path that loads a 128x64 OLED frame image (512 x 16-bit words) from a host into SDRAM. It deserialises 8N1 bytes arriving on RXD at 115200 baud, pairs them into 16-bit words, and issues one write per word through the call/done handshake of ZSDRAM_Module_Base. It is the receiving counterpart of the existing UART transmit step sequence and the host-side writer for the frame buffer that the OLED refresh path reads.

## Interface
Parameters:
- BAUD_DIV, 1157: clock1 cycles per UART bit (133 MHz / 115200).
- FRAME_WORDS, 512: words per frame (1024 bytes).
- BASE_ADDR, 24'd0: SDRAM word address of frame word 0 (Bank+Row+Column).

Ports:
- clock1  in  1  system clock, 133 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- RXD  in  1  UART serial input, idle high, asynchronous to clock1.
- oAddr  out  24  SDRAM write address, to iAddr.
- oData  out  16  SDRAM write data, to iData.
- oCall  out  2  to iCall; [1] is the write request, [0] is tied 0.
- iDone  in  2  from oDone; [1] is write done, [0] is ignored.
- oFrameDone  out  1  one-cycle pulse when the last word of a frame has been written.
- oErr  out  1  sticky framing error.
- oOvr  out  1  sticky overrun.
- oBusy  out  1  high while a byte is being received or a write is pending.

## Operation
- RXD passes through a 2-FF synchroniser. All logic uses the synchronised bit.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a high-to-low transition moves to START with the bit counter cleared.
  - START: wait BAUD_DIV/2 cycles (integer divide), then sample. If the sample is low, go to DATA. If high, treat it as a glitch and return to IDLE with no error.
  - DATA: 8 samples, one every BAUD_DIV cycles, LSB first.
  - STOP: sample after BAUD_DIV cycles. If high, the byte is valid. If low, set oErr, discard the byte and return to IDLE. The byte-pair state is kept.
- Byte pairing: the first valid byte is the high byte and the second is the low byte, so oData = {b0, b1}. On the second byte the word is latched into the hold register and a write is requested.
- Write FSM states: WIDLE, WREQ, WGAP.
  - WREQ: oCall[1]=1, held until iDone[1]=1.
  - On the cycle iDone[1] is seen: drop oCall[1], increment the word index, go to WGAP for 1 cycle, then WIDLE.
  - oAddr and oData are stable throughout WREQ.
- Address: oAddr = BASE_ADDR + index. The index counts 0..FRAME_WORDS-1 and wraps to 0.
  - On completion of the write at index FRAME_WORDS-1, oFrameDone pulses for 1 cycle, on the cycle oCall[1] drops.
- Overrun: if a new word completes while the write FSM is not in WIDLE, drop the new word, set oOvr, and leave index and hold register unchanged.
- oErr and oOvr clear only on reset.

## Timing
- Reset values:
  - oCall=2'b00, oAddr=BASE_ADDR, oData=16'h0000.
  - oFrameDone=0, oErr=0, oOvr=0, oBusy=0.
  - Both FSMs idle, index=0, byte-pair phase=high byte.
- Sample points: start bit at edge+BAUD_DIV/2. Data bit k at edge+BAUD_DIV/2+(k+1)*BAUD_DIV. Stop bit at edge+BAUD_DIV/2+9*BAUD_DIV. Edge time is measured after the synchroniser (2-cycle lag).
- Write latency: oCall[1] asserts the cycle after the second byte's stop-bit sample.
- Resynchronisation: after the stop sample, the RX FSM returns to IDLE immediately, so back-to-back frames with a single stop bit are received.
- Mid-operation reset: all state clears asynchronously, and oCall[1] drops immediately. Any partial word or in-flight write is abandoned. The next frame restarts at BASE_ADDR.
- Simultaneous events: a stop-bit sample on the same cycle as iDone[1] is not an overrun. The write FSM leaves WREQ that cycle, and the new word is accepted after WGAP. The accept must be registered so no word is lost.

## Test plan
- Single word: send 0xAB then 0xCD. Expect one write with oAddr=0, oData=16'hABCD, oCall[1] held until iDone[1], then index=1.
- Full frame: send 1024 bytes with byte n = n[7:0], using an SDRAM model with a 10-cycle done latency.
  - Expect 512 writes at addresses 0..511 with the correct data.
  - Expect exactly one oFrameDone pulse.
  - Expect the next word to go to address 0.
- Framing error: send a byte whose stop bit is 0, then 0x12, 0x34. Expect oErr=1 with no write from the bad byte. Expect the next write to be 16'h1234 if the bad byte was a first byte.
- Glitch: a 200-cycle low pulse on RXD. Expect no byte, no error, and the FSM back in IDLE.
- Overrun: hold iDone[1]=0 indefinitely and send 4 bytes. Expect the first word held on oData, oOvr=1, and the second word dropped.
- Reset mid-write: assert rst_n low while oCall[1]=1. Expect all outputs at reset values. After release, a new pair is written at BASE_ADDR.
